// File: rtl/result_streamer.sv
// Result readout path: captures one row of accumulator results on a store strobe and
// serialises it byte-by-byte, low byte of result1 first, onto the 8-bit host bus.
module result_streamer #(
    parameter int unsigned RESULT_W    = 16,
    parameter int unsigned NUM_RESULTS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                store_result,
    input  logic [RESULT_W-1:0] result1,
    input  logic [RESULT_W-1:0] result2,
    input  logic [RESULT_W-1:0] result3,
    input  logic [RESULT_W-1:0] result4,
    input  logic                fetch_r,
    input  logic                host_ready,
    output logic [7:0]          uo_out,
    output logic                out_valid,
    output logic                out_last,
    output logic                full,
    output logic                overflow
);

    localparam int unsigned BytesPerResult = RESULT_W / 8;
    localparam int unsigned TotalBytes     = NUM_RESULTS * BytesPerResult;
    localparam int unsigned PtrW           = (TotalBytes > 1) ? $clog2(TotalBytes) : 1;
    localparam logic [PtrW-1:0] LastPtr    = PtrW'(TotalBytes - 1);

    typedef enum logic [1:0] {
        StEmpty,
        StHeld,
        StStream
    } state_e;

    state_e                     state_q, state_d;
    logic [TotalBytes-1:0][7:0] row_q, row_d;
    logic [PtrW-1:0]            ptr_q, ptr_d;
    logic [PtrW-1:0]            ptr_inc;
    logic [7:0]                 uo_d;
    logic                       valid_d, last_d, full_d, overflow_d;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        ptr_d      = ptr_q;
        uo_d       = uo_out;
        valid_d    = out_valid;
        last_d     = out_last;
        full_d     = full;
        overflow_d = overflow;
        ptr_inc    = ptr_q + PtrW'(1);

        unique case (state_q)
            StEmpty: begin
                if (store_result) begin
                    row_d   = {result4, result3, result2, result1};
                    state_d = StHeld;
                    full_d  = 1'b1;
                end
            end
            StHeld: begin
                if (store_result) overflow_d = 1'b1;
                if (fetch_r) begin
                    state_d = StStream;
                    ptr_d   = '0;
                    uo_d    = row_q[0];
                    valid_d = 1'b1;
                    last_d  = (LastPtr == '0);
                end
            end
            StStream: begin
                // A store here, including on the final consuming edge, is always dropped.
                if (store_result) overflow_d = 1'b1;
                if (out_valid && host_ready) begin
                    if (ptr_q == LastPtr) begin
                        state_d = StEmpty;
                        ptr_d   = '0;
                        uo_d    = 8'h00;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        full_d  = 1'b0;
                    end else begin
                        ptr_d   = ptr_inc;
                        uo_d    = row_q[ptr_inc];
                        last_d  = (ptr_inc == LastPtr);
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            row_q     <= '0;
            ptr_q     <= '0;
            uo_out    <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            full      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            ptr_q     <= ptr_d;
            uo_out    <= uo_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            full      <= full_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer: 16-bit and 8-bit builds driven in lockstep, compared every
// cycle against a queue-style row model, plus directed sequence checks.
module tb_result_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        store = 1'b0;
    logic        fetch = 1'b0;
    logic        hready = 1'b1;
    logic [15:0] res [4];

    logic [7:0] uo16, uo8;
    logic       valid16, last16, full16, ovf16;
    logic       valid8, last8, full8, ovf8;

    int errors = 0;
    int checks = 0;

    // Model: per build (0 = 16-bit, 1 = 8-bit) the captured byte list and read position.
    logic [7:0] mb [2][8];
    int         mhead [2];
    int         mcnt  [2];
    bit         mbusy [2];
    bit         mstart[2];
    bit         movf  [2];

    logic [7:0] got16[$];
    logic [7:0] got8[$];
    logic [7:0] e1[$] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    logic [7:0] e8[$] = '{8'h01, 8'h02, 8'h03, 8'h04};

    always #5 clk = ~clk;

    result_streamer #(.RESULT_W(16), .NUM_RESULTS(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .store_result(store),
        .result1(res[0]), .result2(res[1]), .result3(res[2]), .result4(res[3]),
        .fetch_r(fetch), .host_ready(hready),
        .uo_out(uo16), .out_valid(valid16), .out_last(last16), .full(full16), .overflow(ovf16)
    );

    result_streamer #(.RESULT_W(8), .NUM_RESULTS(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .store_result(store),
        .result1(res[0][7:0]), .result2(res[1][7:0]), .result3(res[2][7:0]),
        .result4(res[3][7:0]),
        .fetch_r(fetch), .host_ready(hready),
        .uo_out(uo8), .out_valid(valid8), .out_last(last8), .full(full8), .overflow(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        if (!rst_n) begin
            mbusy[d] = 0; mstart[d] = 0; movf[d] = 0; mcnt[d] = 0; mhead[d] = 0;
        end else if (!mbusy[d]) begin
            if (store) begin
                for (int i = 0; i < 4; i++) begin
                    if (d == 0) begin
                        mb[0][2*i]   = res[i][7:0];
                        mb[0][2*i+1] = res[i][15:8];
                    end else begin
                        mb[1][i] = res[i][7:0];
                    end
                end
                mbusy[d] = 1; mstart[d] = 0; mhead[d] = 0;
                mcnt[d] = (d == 0) ? 8 : 4;
            end
        end else begin
            if (store) movf[d] = 1;
            if (!mstart[d]) begin
                if (fetch) mstart[d] = 1;
            end else if (hready) begin
                mhead[d]++;
                mcnt[d]--;
                if (mcnt[d] == 0) begin
                    mbusy[d] = 0; mstart[d] = 0;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_byte(input int d);
        return mstart[d] ? mb[d][mhead[d]] : 8'h00;
    endfunction

    task automatic check_outputs();
        check("uo16",    32'(uo16),    32'(exp_byte(0)));
        check("valid16", 32'(valid16), 32'(mstart[0]));
        check("last16",  32'(last16),  32'(mstart[0] && mcnt[0] == 1));
        check("full16",  32'(full16),  32'(mbusy[0]));
        check("ovf16",   32'(ovf16),   32'(movf[0]));
        check("uo8",     32'(uo8),     32'(exp_byte(1)));
        check("valid8",  32'(valid8),  32'(mstart[1]));
        check("last8",   32'(last8),   32'(mstart[1] && mcnt[1] == 1));
        check("full8",   32'(full8),   32'(mbusy[1]));
        check("ovf8",    32'(ovf8),    32'(movf[1]));
    endtask

    // Inputs are already set; log what the coming edge consumes, clock, then compare.
    task automatic tick();
        if (valid16 && hready) got16.push_back(uo16);
        if (valid8 && hready) got8.push_back(uo8);
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_row(input logic [15:0] a, b, c, d);
        res[0] = a; res[1] = b; res[2] = c; res[3] = d;
        store = 1'b1;
        tick();
        store = 1'b0;
    endtask

    task automatic fetch_once();
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
    endtask

    task automatic cmp_seq(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size()) check({tag, "_byte"}, 32'(got[i]), 32'(exp[i]));
    endtask

    initial begin
        int n78;
        for (int i = 0; i < 4; i++) res[i] = 16'h0000;
        for (int d = 0; d < 2; d++) begin
            mbusy[d] = 0; mstart[d] = 0; movf[d] = 0; mcnt[d] = 0; mhead[d] = 0;
        end
        @(negedge clk);
        do_reset();
        check("rst_valid", 32'(valid16), 32'd0);
        check("rst_full", 32'(full16), 32'd0);

        // Basic stream with host always ready.
        load_row(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        check("t1_full", 32'(full16), 32'd1);
        got16.delete(); got8.delete();
        fetch_once();
        check("t1_first", 32'(uo16), 32'h34);
        repeat (7) tick();
        check("t1_lastbyte", 32'(uo16), 32'hDE);
        check("t1_lastflag", 32'(last16), 32'd1);
        tick();
        check("t1_full_fall", 32'(full16), 32'd0);
        check("t1_valid_fall", 32'(valid16), 32'd0);
        cmp_seq("t1_seq16", got16, e1);

        // Host stalls three cycles on byte 0x78.
        load_row(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        got16.delete();
        fetch_once();
        n78 = 0;
        for (int k = 0; k < 12; k++) begin
            hready = (k < 2 || k > 4);
            tick();
            if (valid16 && uo16 == 8'h78) n78++;
        end
        hready = 1'b1;
        check("t2_hold78", 32'(n78), 32'd4);
        cmp_seq("t2_seq16", got16, e1);

        // Fetch while empty is ignored.
        do_reset();
        fetch_once();
        check("t3_valid", 32'(valid16), 32'd0);
        check("t3_uo", 32'(uo16), 32'd0);
        tick();
        load_row(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        got16.delete();
        fetch_once();
        repeat (9) tick();
        cmp_seq("t3_seq16", got16, e1);

        // Stores while held and mid-stream are dropped.
        do_reset();
        load_row(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        load_row(16'hAAAA, 16'h5678, 16'h9ABC, 16'hDEF0);
        check("t4_ovf_held", 32'(ovf16), 32'd1);
        got16.delete();
        fetch_once();
        tick();
        load_row(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
        repeat (8) tick();
        cmp_seq("t4_seq16", got16, e1);
        check("t4_ovf_sticky", 32'(ovf16), 32'd1);

        // Reset mid-stream aborts; a fetch without a new store emits nothing.
        load_row(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        fetch_once();
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_valid", 32'(valid16), 32'd0);
        check("t5_full", 32'(full16), 32'd0);
        check("t5_ovf", 32'(ovf16), 32'd0);
        got16.delete();
        fetch_once();
        repeat (3) tick();
        check("t5_none", 32'(got16.size()), 32'd0);

        // 8-bit build emits exactly four bytes.
        load_row(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        got8.delete();
        fetch_once();
        repeat (3) tick();
        check("t6_last_uo", 32'(uo8), 32'h04);
        check("t6_last_flag", 32'(last8), 32'd1);
        repeat (3) tick();
        cmp_seq("t6_seq8", got8, e8);

        // Randomised traffic, including occasional resets.
        for (int c = 0; c < 3000; c++) begin
            store  = ($urandom_range(0, 7) == 0);
            fetch  = ($urandom_range(0, 5) == 0);
            hready = ($urandom_range(0, 9) < 7);
            rst_n  = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 4; i++) res[i] = 16'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
- Host-side readout path: the mirror of the weight load path. The load path moves bytes from ui_in into local memory; this block moves results from local storage out to uo_out.
- Captures one row of NUM_RESULTS accumulator results from the systolic array / accumulator stage on a store strobe.
- On host fetch request, serialises the row byte-by-byte onto the 8-bit output bus with valid/last flags and a host-ready stall.
- Sits between the accumulator outputs and the top-level uo_out mux.

Parameters:
- RESULT_W, 16, width of each result in bits; legal values 8 or 16. Derived: BYTES_PER_RESULT = RESULT_W/8.
- NUM_RESULTS, 4, results captured per row; fixed at 4 to match the four result ports. Derived: TOTAL_BYTES = NUM_RESULTS*BYTES_PER_RESULT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- store_result  in  1  capture pulse; samples result1..result4
- result1  in  RESULT_W  array column 0 result
- result2  in  RESULT_W  array column 1 result
- result3  in  RESULT_W  array column 2 result
- result4  in  RESULT_W  array column 3 result
- fetch_r  in  1  host request to start readout
- host_ready  in  1  host accepts current byte this cycle
- uo_out  out  8  output byte
- out_valid  out  1  uo_out holds a valid byte
- out_last  out  1  current byte is the final byte of the row
- full  out  1  a captured row is waiting or streaming
- overflow  out  1  sticky: a store was dropped

Behaviour:
- Single clock domain. Reset is synchronous, active-low: rst_n sampled low at a clk edge resets the block.
- Reset values: state=EMPTY; buffer=0; byte pointer=0; uo_out=0; out_valid=0; out_last=0; full=0; overflow=0. Reset mid-stream aborts immediately; no further bytes are emitted.
- All outputs are registered.
- EMPTY:
  - store_result=1 -> capture result1..4 into buffer; go to HELD; full=1 from the next cycle.
  - fetch_r is ignored.
- HELD:
  - fetch_r=1 -> go to STREAM; pointer=0; byte 0 appears on uo_out with out_valid=1 in the cycle after fetch_r is sampled (latency 1).
  - store_result=1 (with or without fetch_r) -> dropped; buffer unchanged; overflow set.
- STREAM:
  - Byte order: result1 low byte, result1 high byte, result2 low, ... result4 high. For RESULT_W=8: result1..result4.
  - Byte k = buffer bits [8k+7:8k], with buffer = {result4,result3,result2,result1}.
  - A byte is consumed on any edge where out_valid=1 and host_ready=1; the next byte is presented in the following cycle.
  - host_ready=0 holds uo_out, out_valid and out_last stable, for unlimited cycles.
  - out_last=1 only while byte TOTAL_BYTES-1 is presented.
  - Consuming the last byte -> EMPTY; out_valid=0, uo_out=0, full=0 next cycle.
  - store_result during STREAM -> dropped, overflow set.
  - fetch_r during STREAM -> ignored (no restart).
- Store on the exact edge where the last byte is consumed: dropped and overflow set. A new capture is accepted only from EMPTY, starting the cycle after.
- uo_out=0 whenever out_valid=0.
- overflow clears only on reset.
- Pointer width ceil(log2(TOTAL_BYTES)). The pointer never wraps; the terminal byte triggers the EMPTY transition.

Test Plan:
- Reset, store result1=0x1234, result2=0x5678, result3=0x9ABC, result4=0xDEF0, then fetch_r with host_ready=1 held -> uo_out sequence 34,12,78,56,BC,9A,F0,DE on 8 consecutive cycles starting 1 cycle after fetch_r; out_last only on DE; full falls the cycle after DE.
- Same data; host_ready low for 3 cycles while byte 78 is presented -> 78 held 4 cycles, out_valid stays 1, no byte lost or duplicated.
- fetch_r pulsed while EMPTY -> out_valid remains 0, uo_out 0; a later store then fetch streams normally.
- Second store_result (result1=0xAAAA) in HELD and again mid-stream -> streamed bytes still come from the first capture; overflow=1 and stays 1 until rst_n low.
- rst_n low for one edge after byte 3 -> next cycle out_valid=0, full=0, overflow=0; a following fetch_r without a store emits nothing.
- RESULT_W=8 build, results 0x01,0x02,0x03,0x04 -> exactly 4 bytes 01,02,03,04; out_last on 04.
